// File: rtl/mem_access_ctrl_if.sv
// Data-memory handshake bundle between the MEM stage and dmem.
// master = MEM-stage sequencer, slave = memory model / arbiter.
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues dmem loads/stores, stalls upstream,
// registers MEM/WB fields; timeout guard (err) + stall counter.
// Ports: clk, reset (sync, high), EX/MEM ctrl/data in,
// dmem (master modport), stall, WB fields out, err, stall_cnt.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             regwrite,
  input  logic             memtoreg,
  input  logic [63:0]      alures,
  input  logic [63:0]      writedata,
  input  logic [4:0]       RD,
  mem_access_ctrl_if.master dmem,
  output logic             stall,
  output logic             regwriteout,
  output logic             memtoregout,
  output logic [63:0]      aluresout,
  output logic [63:0]      readmemout,
  output logic [4:0]       RDout,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [TW-1:0]    r_tcnt;
  logic             r_req;
  logic             r_we;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic             r_rw;
  logic             r_m2r;
  logic [63:0]      r_alu;
  logic [63:0]      r_rdm;
  logic [4:0]       r_rd;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_memop;
  logic w_idle;
  logic w_busy;
  logic w_tout;
  logic w_done;
  logic w_rd_nz;

  assign w_memop = valid & (memread | memwrite);
  assign w_idle  = (r_state == S_IDLE);
  assign w_busy  = (r_state == S_BUSY);
  assign w_tout  = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_done  = dmem.dmem_ack | w_tout;
  assign w_rd_nz = (RD != 5'd0);

  assign stall = (w_idle & w_memop) | (w_busy & ~w_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_alu   <= '0;
      r_rdm   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (stall && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
      unique case (1'b1)
        w_idle && !w_memop: begin
          r_rw  <= valid & regwrite & w_rd_nz;
          r_m2r <= memtoreg;
          r_alu <= alures;
          r_rd  <= RD;
          r_rdm <= '0;
        end
        w_idle && w_memop: begin
          r_rw    <= 1'b0;
          r_m2r   <= 1'b0;
          r_alu   <= '0;
          r_rd    <= '0;
          r_rdm   <= '0;
          r_addr  <= alures;
          r_wdata <= writedata;
          // read+write together is a store
          r_we    <= memwrite;
          r_req   <= 1'b1;
          r_tcnt  <= '0;
          r_state <= S_BUSY;
        end
        w_busy && !w_done: begin
          r_rw   <= 1'b0;
          r_m2r  <= 1'b0;
          r_alu  <= '0;
          r_rd   <= '0;
          r_rdm  <= '0;
          r_tcnt <= r_tcnt + 1'b1;
        end
        default: begin
          // completion; a coincident ack beats the timeout
          r_rw    <= dmem.dmem_ack & regwrite & w_rd_nz;
          r_m2r   <= memtoreg;
          r_alu   <= alures;
          r_rd    <= RD;
          r_rdm   <= (dmem.dmem_ack && !r_we) ?
                     dmem.dmem_rdata : 64'd0;
          r_err   <= r_err | ~dmem.dmem_ack;
          r_req   <= 1'b0;
          r_tcnt  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign regwriteout = r_rw;
  assign memtoregout = r_m2r;
  assign aluresout   = r_alu;
  assign readmemout  = r_rdm;
  assign RDout       = r_rd;
  assign err         = r_err;
  assign stall_cnt   = r_cnt;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the 5-stage RISC-V pipeline: drives a handshaked data-memory port for loads/stores, stalls upstream stages until the access completes, and registers the completed result into the MEM/WB fields. It sits between the EX/MEM register and the WB mux. It also provides a timeout guard and a stall-cycle counter.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting for dmem_ack before forced completion (≥2)
- CNT_W, 32: width of stall-cycle counter
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- valid  in  1  EX/MEM holds a live instruction
- memread, memwrite, regwrite, memtoreg  in  1 each  EX/MEM control
- alures  in  64  address / ALU result
- writedata  in  64  store data
- RD  in  5  destination register
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1=store, registered
- dmem_addr  out  64  registered copy of alures
- dmem_wdata  out  64  registered copy of writedata
- dmem_rdata  in  64  load data, valid with dmem_ack
- dmem_ack  in  1  single-cycle completion strobe
- stall  out  1  combinational, freezes PC/IF/ID/EX/MEM
- regwriteout, memtoregout  out  1 each  to WB
- aluresout, readmemout  out  64 each  to WB
- RDout  out  5  to WB
- err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  saturating count of stall-high cycles

## Operation
- States: IDLE, BUSY. memop = valid & (memread | memwrite). memread & memwrite both high treated as store.
- IDLE: memop=0 → outputs pass-through registered (regwriteout=valid&regwrite, memtoregout, aluresout, RDout from inputs; readmemout=0). memop=1 → stall=1, outputs take bubble (regwriteout=0, memtoregout=0, RDout=0), latch dmem_addr/wdata/we, dmem_req←1, go BUSY.
- BUSY: wait counter tcnt increments each cycle from 0. done = dmem_ack | (tcnt==TIMEOUT-1).
  - done=0: stall=1, bubble to WB, dmem_req stays 1, address/data/we stable.
  - done=1 via ack: stall=0; capture regwriteout=regwrite, memtoregout, aluresout=alures, RDout=RD, readmemout=dmem_rdata if load else 0; dmem_req←0; go IDLE.
  - done=1 via timeout (no ack): same capture but regwriteout=0, readmemout=0; err←1; dmem_req←0; go IDLE.
  - ack and timeout same cycle: ack wins, err unchanged.
- dmem_ack outside BUSY is ignored.
- regwriteout forced 0 whenever RD==0 (x0 never written).
- stall = (state==IDLE & memop) | (state==BUSY & ~done).
- stall_cnt increments each cycle stall=1; holds at all-ones.
- reset: state IDLE, tcnt 0, dmem_req/we 0, dmem_addr/wdata 0, all WB outputs 0, err 0, stall_cnt 0. Reset in BUSY abandons the access; dmem_req low next cycle; in-flight ack after reset ignored.

## Timing
- Non-memory instruction: 1-cycle latency input→WB outputs, no stall.
- Load/store with ack in first BUSY cycle: stall high 1 cycle, result at WB outputs 2 edges after instruction enters MEM.
- Ack k cycles after dmem_req rises (k≥0 counting the rising cycle as 0): stall high k+1 cycles.
- Timeout: stall high TIMEOUT cycles, then bubble-free completion with regwrite suppressed.
- Back-to-back memops: IDLE entry the cycle after completion; min 2 cycles per memop.
- stall is combinational from valid/memread/memwrite/dmem_ack; no other comb paths to outputs.

## Test plan
- Reset then ALU op (valid=1, regwrite=1, alures=0x1234, RD=5) → next edge regwriteout=1, aluresout=0x1234, RDout=5, readmemout=0, stall never high.
- Load addr 0x100, RD=7, ack at first BUSY cycle with rdata=0xDEADBEEF → stall high 1 cycle, dmem_addr=0x100, dmem_we=0, then readmemout=0xDEADBEEF, memtoregout=1, RDout=7, stall_cnt=1.
- Store addr 0x80 data 0x55, ack after 3 wait cycles → dmem_we=1, dmem_wdata=0x55 stable throughout, stall high 4 cycles, regwriteout=0 at completion.
- Load with no ack, TIMEOUT=16 → stall high 16 cycles, err=1 sticky, regwriteout=0; following ALU op completes normally, err remains 1.
- Load to RD=0 with ack → regwriteout=0; back-to-back two loads each ack immediately → second dmem_req rises the cycle after first completes.
- Reset asserted mid-BUSY, then late ack → all outputs 0, dmem_req=0 next cycle, ack ignored, stall_cnt=0.
